rs232_rxbuf: RTL and testbench

RS232_RXBUF -- requirements
Module: rs232_rxbuf

---
 rtl/rs232_rxbuf.sv | 86 ++++++++
 tb/tb_rs232_rxbuf.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rs232_rxbuf.sv
// rs232_rxbuf: RS232 receive FIFO with one-shot capture handshake.
// Define RS232_RXBUF_OVERRUN_EN to enable the sticky ovr flag and drop_cnt.
module rs232_rxbuf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_done,
  input  logic          rd,
  output logic [7:0]    rd_data,
  output logic          rdy,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovr,
  input  logic          clr_ovr,
  output logic [7:0]    drop_cnt
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic capture, pop, wr, drop;
  assign count   = count_q;
  assign rdy     = count_q != '0;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign rd_data = mem_q[rptr_q];
  always_comb begin
    capture = (state_q == IDLE) && rx_rdy;
    pop     = rd && rdy;
    wr      = capture && (!full || pop);
    drop    = capture && full && !pop;
    rx_done = capture && rst_n;
    // WAIT persists while rx_rdy stays high, so a held byte is taken only once
    state_d = rx_rdy ? WAIT : IDLE;
    wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = (wr && !pop) ? count_q + (AW+1)'(1) :
              (pop && !wr) ? count_q - (AW+1)'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= rx_data;
  end
`ifdef RS232_RXBUF_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic [7:0] drop_cnt_q, drop_cnt_d, drop_base;
  always_comb begin
    // a drop in the same cycle as clr_ovr wins: the count restarts at 1
    drop_base  = clr_ovr ? 8'd0 : drop_cnt_q;
    ovr_d      = drop || (ovr_q && !clr_ovr);
    drop_cnt_d = (drop && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovr_q      <= ovr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign ovr      = ovr_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_ovr;
  assign unused_ovr = clr_ovr ^ drop;
  assign ovr        = 1'b0;
  assign drop_cnt   = '0;
`endif
endmodule

// File: tb/tb_rs232_rxbuf.sv
// tb_rs232_rxbuf: table-driven and scoreboard checks for rs232_rxbuf.
module tb_rs232_rxbuf;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, rst_n = 0, rx_rdy = 0, rd = 0, clr_ovr = 0;
  logic [7:0] rx_data = '0;
  logic rx_done, rdy, full, ovr;
  logic [7:0] rd_data, drop_cnt;
  logic [AW:0] count;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [7:0] exp_q[$];
  bit m_ovr = 0;
  int m_drops = 0;

  rs232_rxbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_done(rx_done),
    .rd(rd), .rd_data(rd_data), .rdy(rdy), .full(full), .count(count),
    .ovr(ovr), .clr_ovr(clr_ovr), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) if (rx_done) done_cnt++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ovr(string name);
`ifdef RS232_RXBUF_OVERRUN_EN
    chk({name, "_ovr"}, int'(ovr), int'(m_ovr));
    chk({name, "_drop"}, int'(drop_cnt), m_drops);
`else
    chk({name, "_ovr"}, int'(ovr), 0);
    chk({name, "_drop"}, int'(drop_cnt), 0);
`endif
  endtask

  // one receiver transaction (optional byte, optional read) followed by one idle cycle
  task automatic step(input bit wr, input logic [7:0] d, input bit r, input bit clr);
    rx_rdy = wr; rx_data = d; rd = r; clr_ovr = clr;
    @(negedge clk);
    if (r && exp_q.size() != 0) chk("rd_data", int'(rd_data), int'(exp_q[0]));
    if (wr) chk("rx_done", int'(rx_done), 1);
    tick();
    if (r && exp_q.size() != 0) void'(exp_q.pop_front());
    if (clr) begin m_ovr = 0; m_drops = 0; end
    if (wr) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else begin m_ovr = 1; if (m_drops < 255) m_drops++; end
    end
    rx_rdy = 0; rd = 0; clr_ovr = 0;
    tick();
  endtask

  task automatic chk_state(string name);
    chk({name, "_count"}, int'(count), exp_q.size());
    chk({name, "_rdy"}, int'(rdy), int'(exp_q.size() != 0));
    chk({name, "_full"}, int'(full), int'(exp_q.size() == DEPTH));
  endtask

  typedef struct {bit wr; logic [7:0] d; bit r; int exp_count;} vec_t;
  vec_t tbl[10];

  initial begin
    int d0;
    tbl = '{'{1, 8'h41, 0, 1}, '{1, 8'h42, 0, 2}, '{1, 8'h43, 0, 3}, '{0, 8'h00, 1, 2},
            '{0, 8'h00, 1, 1}, '{1, 8'h44, 1, 1}, '{0, 8'h00, 1, 0}, '{0, 8'h00, 1, 0},
            '{1, 8'h55, 0, 1}, '{0, 8'h00, 1, 0}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_rx_done", int'(rx_done), 0);
    chk_ovr("rst");
    rst_n = 1;
    tick();

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].r, 0);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
      chk($sformatf("tbl%0d_rdy", i), int'(rdy), int'(tbl[i].exp_count != 0));
      if (i == 2) chk("tbl_head", int'(rd_data), 8'h41);
    end

    // rx_rdy held high after the acknowledge
    d0 = done_cnt;
    rx_rdy = 1; rx_data = 8'h77;
    repeat (6) tick();
    rx_rdy = 0;
    tick();
    exp_q.push_back(8'h77);
    chk("hold_done", done_cnt - d0, 1);
    chk_state("hold");
    step(0, 0, 1, 0);
    chk_state("hold_drain");

    // fill to full, then overrun by two
    for (int i = 0; i < DEPTH + 2; i++) step(1, 8'(8'h80 + i), 0, 0);
    chk_state("fill");
    chk("fill_head", int'(rd_data), 8'h80);
    chk_ovr("fill");
    step(1, 8'hEE, 0, 1);
    chk_ovr("clr_prio");
    step(0, 0, 0, 1);
    chk_ovr("clr");
    step(1, 8'hA5, 1, 0);
    chk_state("full_rw");
    chk_ovr("full_rw");
    while (exp_q.size() != 0) step(0, 0, 1, 0);
    chk_state("drain_full");

    // wrap-around traffic with interleaved reads
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h10 + i), i % 4 != 0, 0);
      chk_state($sformatf("wrap%0d", i));
    end
    while (exp_q.size() != 0) step(0, 0, 1, 0);
    chk_state("wrap_drain");
    chk_ovr("wrap");

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0);
    @(posedge clk);
    #3;
    rx_rdy = 1; rx_data = 8'h66; rst_n = 0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_rdy", int'(rdy), 0);
    chk("arst_rx_done", int'(rx_done), 0);
    exp_q.delete(); m_ovr = 0; m_drops = 0;
    @(negedge clk);
    chk("arst_hold_done", int'(rx_done), 0);
    rx_rdy = 0;
    @(posedge clk);
    #3;
    rst_n = 1;
    d0 = done_cnt;
    repeat (2) tick();
    chk("arst_no_done", done_cnt - d0, 0);
    chk_state("arst_rel");

    // release with a byte pending
    #2;
    rst_n = 0; rx_rdy = 1; rx_data = 8'h99;
    @(posedge clk);
    #3;
    rst_n = 1;
    @(negedge clk);
    chk("rel_done", int'(rx_done), 1);
    tick();
    exp_q.push_back(8'h99);
    chk_state("rel_cap");
    chk("rel_data", int'(rd_data), 8'h99);
    rx_rdy = 0;
    tick();
    step(0, 0, 1, 0);
    chk_state("rel_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
